// File: rtl/otp_pkg.sv
// Shared types and default constants for the OTP generator, verifier and bench.
// The verifier state encoding lives here so display logic can decode it too.
package otp_pkg;

  localparam int OTP_CODE_W          = 4;
  localparam int OTP_MAX_ATTEMPTS    = 3;
  localparam int OTP_TIMEOUT_CYCLES  = 1000;
  localparam int OTP_LOCK_CYCLES     = 5000;
  localparam int OTP_ATT_W           = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_PASS   = 3'd3,
    ST_FAIL   = 3'd4,
    ST_LOCKED = 3'd5
  } otp_state_e;

endpackage

// File: rtl/otp_edge_detect.sv
// Rising-edge detector for an already-synchronous level.
// The history bit resets low, so a level high at the first edge counts as a rise.
module otp_edge_detect (
  input  logic clk,
  input  logic reset_n_delay,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or posedge reset_n_delay) begin
    if (reset_n_delay) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/otp_verify_fsm.sv
// OTP verification stage: captures OTP and user digits, compares them,
// counts attempts, expires stale OTPs and enforces a timed lockout.
module otp_verify_fsm
  import otp_pkg::*;
#(
  parameter int CODE_W         = OTP_CODE_W,
  parameter int MAX_ATTEMPTS   = OTP_MAX_ATTEMPTS,
  parameter int TIMEOUT_CYCLES = OTP_TIMEOUT_CYCLES,
  parameter int LOCK_CYCLES    = OTP_LOCK_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n_delay,
  input  logic [CODE_W-1:0] otp_code,
  input  logic              otp_latch,
  input  logic [CODE_W-1:0] user_in,
  input  logic              user_latch,
  output logic              pass,
  output logic              fail,
  output logic              expired,
  output logic              armed,
  output logic              locked,
  output logic [2:0]        attempts_left
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int LW = $clog2(LOCK_CYCLES);

  localparam logic [2:0]    ATT_MAX  = 3'(MAX_ATTEMPTS);
  localparam logic [TW-1:0] TIME_END = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_END = LW'(LOCK_CYCLES - 1);

  otp_state_e        state, state_d;
  logic [CODE_W-1:0] otp_reg, otp_d;
  logic [CODE_W-1:0] user_reg, user_d;
  logic [TW-1:0]     timer, timer_d;
  logic [LW-1:0]     lock_cnt, lock_d;
  logic [2:0]        att_q, att_d;
  logic              exp_flag, exp_d;
  logic              otp_rise;
  logic              user_rise;

  otp_edge_detect u_otp_edge (
    .clk           (clk),
    .reset_n_delay (reset_n_delay),
    .sig           (otp_latch),
    .rise          (otp_rise)
  );

  otp_edge_detect u_user_edge (
    .clk           (clk),
    .reset_n_delay (reset_n_delay),
    .sig           (user_latch),
    .rise          (user_rise)
  );

  always_ff @(posedge clk or posedge reset_n_delay) begin
    if (reset_n_delay) begin
      state    <= ST_IDLE;
      otp_reg  <= '0;
      user_reg <= '0;
      timer    <= '0;
      lock_cnt <= '0;
      att_q    <= ATT_MAX;
      exp_flag <= 1'b0;
    end else begin
      state    <= state_d;
      otp_reg  <= otp_d;
      user_reg <= user_d;
      timer    <= timer_d;
      lock_cnt <= lock_d;
      att_q    <= att_d;
      exp_flag <= exp_d;
    end
  end

  always_comb begin
    state_d = state;
    otp_d   = otp_reg;
    user_d  = user_reg;
    timer_d = timer;
    lock_d  = lock_cnt;
    att_d   = att_q;
    exp_d   = exp_flag;
    unique case (state)
      ST_IDLE: begin
        if (otp_rise) begin
          otp_d   = otp_code;
          att_d   = ATT_MAX;
          timer_d = '0;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (otp_rise) begin
          otp_d   = otp_code;
          att_d   = ATT_MAX;
          timer_d = '0;
        end else if (user_rise) begin
          user_d  = user_in;
          state_d = ST_CHECK;
        end else if (timer == TIME_END) begin
          exp_d   = 1'b1;
          state_d = ST_FAIL;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      ST_CHECK: begin
        if (user_reg == otp_reg) begin
          state_d = ST_PASS;
        end else begin
          att_d = att_q - 3'd1;
          if (att_d == 3'd0) begin
            lock_d  = '0;
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_PASS: begin
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        if (exp_flag) begin
          exp_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          timer_d = '0;
          state_d = ST_ARMED;
        end
      end
      ST_LOCKED: begin
        if (lock_cnt == LOCK_END) begin
          att_d   = ATT_MAX;
          state_d = ST_IDLE;
        end else begin
          lock_d = lock_cnt + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore decode: outputs depend only on registered state.
  assign pass          = (state == ST_PASS);
  assign fail          = (state == ST_FAIL);
  assign expired       = (state == ST_FAIL) & exp_flag;
  assign armed         = (state == ST_ARMED) | (state == ST_CHECK);
  assign locked        = (state == ST_LOCKED);
  assign attempts_left = att_q;

endmodule

// File: tb/tb_otp_verify_fsm.sv
// Directed bench for otp_verify_fsm: table-driven entries plus
// hand-written expiry, simultaneous-edge, lockout and reset sequences.
module tb_otp_verify_fsm;

  localparam int T_CYC = 20;
  localparam int L_CYC = 10;

  logic       clk = 1'b0;
  logic       reset_n_delay;
  logic [3:0] otp_code;
  logic       otp_latch;
  logic [3:0] user_in;
  logic       user_latch;
  logic       pass;
  logic       fail;
  logic       expired;
  logic       armed;
  logic       locked;
  logic [2:0] attempts_left;

  int tests = 0;
  int fails = 0;

  otp_verify_fsm #(
    .CODE_W         (4),
    .MAX_ATTEMPTS   (3),
    .TIMEOUT_CYCLES (T_CYC),
    .LOCK_CYCLES    (L_CYC)
  ) dut (
    .clk           (clk),
    .reset_n_delay (reset_n_delay),
    .otp_code      (otp_code),
    .otp_latch     (otp_latch),
    .user_in       (user_in),
    .user_latch    (user_latch),
    .pass          (pass),
    .fail          (fail),
    .expired       (expired),
    .armed         (armed),
    .locked        (locked),
    .attempts_left (attempts_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       enter;
    bit [3:0] code;
    bit       e_pass;
    bit       e_fail;
    bit       e_lock;
    int       e_att;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic arm(input bit [3:0] code, input int e_att);
    otp_code  = code;
    otp_latch = 1'b1;
    tick();
    chk("arm_armed", int'(armed), 1);
    chk("arm_att", int'(attempts_left), e_att);
    otp_latch = 1'b0;
    tick();
  endtask

  task automatic enter(input bit [3:0] code, input bit ep, input bit ef,
                       input bit el, input int ea);
    user_in    = code;
    user_latch = 1'b1;
    tick();
    chk("check_armed", int'(armed), 1);
    user_latch = 1'b0;
    tick();
    chk("res_pass", int'(pass), int'(ep));
    chk("res_fail", int'(fail), int'(ef));
    chk("res_lock", int'(locked), int'(el));
    chk("res_exp", int'(expired), 0);
    chk("res_att", int'(attempts_left), ea);
    if (!el) begin
      tick();
      chk("after_armed", int'(armed), int'(ef));
      chk("after_pf", int'(pass | fail), 0);
    end
  endtask

  initial begin
    int n;
    int cnt;
    bit seen;

    vecs[0] = '{1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 3};
    vecs[1] = '{1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 3};
    vecs[2] = '{1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 3};
    vecs[3] = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 2};
    vecs[4] = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1};
    vecs[5] = '{1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1};
    vecs[6] = '{1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 3};
    vecs[7] = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 2};
    vecs[8] = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1};
    vecs[9] = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 0};

    reset_n_delay = 1'b1;
    otp_code      = 4'h0;
    otp_latch     = 1'b0;
    user_in       = 4'h0;
    user_latch    = 1'b0;
    tick();
    tick();
    chk("rst_pass", int'(pass), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_att", int'(attempts_left), 3);
    reset_n_delay = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].enter)
        enter(vecs[i].code, vecs[i].e_pass, vecs[i].e_fail,
              vecs[i].e_lock, vecs[i].e_att);
      else
        arm(vecs[i].code, vecs[i].e_att);
    end

    // Lockout duration, with a user pulse that must be ignored
    n    = 1;
    seen = 1'b0;
    for (int i = 0; i < 30 && locked; i++) begin
      if (i == 2) user_latch = 1'b1;
      if (i == 4) user_latch = 1'b0;
      tick();
      if (locked) n++;
      if (pass | fail) seen = 1'b1;
    end
    user_latch = 1'b0;
    chk("lock_len", n, L_CYC);
    chk("lock_no_pf", int'(seen), 0);
    chk("lock_exit_armed", int'(armed), 0);
    chk("lock_exit_att", int'(attempts_left), 3);
    tick();
    chk("lock_idle_armed", int'(armed), 0);

    // Expiry: arming edge a, fail+expired at a+T_CYC
    otp_code  = 4'h5;
    otp_latch = 1'b1;
    tick();
    otp_latch = 1'b0;
    seen = 1'b0;
    for (int m = 1; m < T_CYC; m++) begin
      tick();
      if (fail | expired | !armed) seen = 1'b1;
    end
    chk("exp_early", int'(seen), 0);
    tick();
    chk("exp_fail", int'(fail), 1);
    chk("exp_expired", int'(expired), 1);
    chk("exp_att", int'(attempts_left), 3);
    tick();
    chk("exp_after_armed", int'(armed), 0);
    chk("exp_after_fail", int'(fail), 0);

    // Simultaneous rises: re-arm with new code, no CHECK
    arm(4'h9, 3);
    repeat (5) tick();
    otp_code   = 4'h6;
    user_in    = 4'h6;
    otp_latch  = 1'b1;
    user_latch = 1'b1;
    tick();
    otp_latch  = 1'b0;
    user_latch = 1'b0;
    tick();
    chk("sim_no_pf", int'(pass | fail), 0);
    chk("sim_armed", int'(armed), 1);
    enter(4'h6, 1'b1, 1'b0, 1'b0, 3);

    // Simultaneous rises clear the timer
    arm(4'h2, 3);
    repeat (5) tick();
    otp_code   = 4'h7;
    user_in    = 4'h7;
    otp_latch  = 1'b1;
    user_latch = 1'b1;
    tick();
    otp_latch  = 1'b0;
    user_latch = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && !fail; i++) begin
      tick();
      cnt++;
    end
    chk("sim_timer", cnt, T_CYC);
    chk("sim_expired", int'(expired), 1);
    tick();

    // Reset during CHECK
    arm(4'h4, 3);
    enter(4'h1, 1'b0, 1'b1, 1'b0, 2);
    user_in    = 4'h1;
    user_latch = 1'b1;
    tick();
    chk("pre_rst_armed", int'(armed), 1);
    reset_n_delay = 1'b1;
    #1;
    chk("rstc_armed", int'(armed), 0);
    chk("rstc_att", int'(attempts_left), 3);
    chk("rstc_pf", int'(pass | fail), 0);
    user_latch = 1'b0;
    #1;
    reset_n_delay = 1'b0;
    tick();
    chk("rstc_idle", int'(armed), 0);

    // Reset during LOCKED
    arm(4'hA, 3);
    enter(4'h0, 1'b0, 1'b1, 1'b0, 2);
    enter(4'h0, 1'b0, 1'b1, 1'b0, 1);
    enter(4'h0, 1'b0, 1'b0, 1'b1, 0);
    tick();
    tick();
    chk("pre_rstl_lock", int'(locked), 1);
    reset_n_delay = 1'b1;
    #1;
    chk("rstl_locked", int'(locked), 0);
    chk("rstl_att", int'(attempts_left), 3);

    // Level already high at release counts as a rise
    otp_code  = 4'h8;
    otp_latch = 1'b1;
    #1;
    reset_n_delay = 1'b0;
    tick();
    chk("rel_high_arms", int'(armed), 1);
    otp_latch = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
